// File: rtl/ssd_scan_scheduler.sv
// Eight-digit seven-segment scan scheduler with a per-slot blanking cycle
// and a retriggerable display flash sequence.
module ssd_scan_scheduler #(
  parameter int SCAN_PERIOD   = 262144,
  parameter int FLASH_TICKS   = 64,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digit_data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_zero,
  input  logic        flash_req,
  output logic [7:0]  an,
  output logic [7:0]  cath,
  output logic        scan_tick,
  output logic        flash_busy
);
  // state  | meaning
  // S_IDLE | no flash, normal display
  // S_OFF  | flash dark phase, anodes forced off
  // S_ON   | flash lit phase, normal display
  typedef enum logic [1:0] {S_IDLE, S_OFF, S_ON} flash_state_t;

  localparam int PW  = $clog2(SCAN_PERIOD);
  localparam int TW  = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam int TGW = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;

  flash_state_t   state;
  logic [PW-1:0]  presc;
  logic [2:0]     ptr;
  logic [TW-1:0]  tick_cnt;
  logic [TGW-1:0] tog_cnt;

  logic       tick_now;
  logic [2:0] ptr_nxt;
  logic [2:0] ptr_eff;
  logic       phase_end;
  logic       last_phase;
  logic       off_nxt;
  logic       found;
  logic [2:0] idx;
  logic [3:0] nib;
  logic [6:0] seg;

  assign tick_now   = (presc == PW'(SCAN_PERIOD - 1));
  assign phase_end  = (tick_cnt == TW'(FLASH_TICKS - 1));
  assign last_phase = (tog_cnt == TGW'(FLASH_TOGGLES - 1));

  // Circular search above ptr; falls back to holding ptr when nothing else is enabled.
  always_comb begin
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = ptr;
    for (int k = 1; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && digit_en[idx]) begin
        ptr_nxt = idx;
        found   = 1'b1;
      end
    end
  end

  // Outputs are computed against the pointer/state they will be shown with.
  assign ptr_eff = scan_tick ? ptr_nxt : ptr;

  always_comb begin
    if (flash_req)
      off_nxt = 1'b1;
    else if (scan_tick && phase_end)
      off_nxt = (state == S_ON) && !last_phase;
    else
      off_nxt = (state == S_OFF);
  end

  assign nib = digit_data[{ptr_eff, 2'b00} +: 4];

  always_comb begin
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    if (blank_zero[ptr_eff] && nib == 4'h0)
      seg = 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      ptr        <= '0;
      state      <= S_IDLE;
      tick_cnt   <= '0;
      tog_cnt    <= '0;
      an         <= 8'hFF;
      cath       <= 8'hFF;
      scan_tick  <= 1'b0;
      flash_busy <= 1'b0;
    end else begin
      presc     <= tick_now ? '0 : presc + 1'b1;
      scan_tick <= tick_now;
      if (scan_tick)
        ptr <= ptr_nxt;

      if (flash_req) begin
        state      <= S_OFF;
        tick_cnt   <= '0;
        tog_cnt    <= '0;
        flash_busy <= 1'b1;
      end else if (state != S_IDLE && scan_tick) begin
        if (phase_end) begin
          tick_cnt <= '0;
          if (last_phase) begin
            state      <= S_IDLE;
            tog_cnt    <= '0;
            flash_busy <= 1'b0;
          end else begin
            state   <= (state == S_OFF) ? S_ON : S_OFF;
            tog_cnt <= tog_cnt + 1'b1;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end

      if (tick_now || off_nxt || !digit_en[ptr_eff])
        an <= 8'hFF;
      else
        an <= ~(8'b1 << ptr_eff);
      cath <= {seg, ~dp_mask[ptr_eff]};
    end
  end

endmodule

// File: doc/ssd_scan_scheduler.md
SSD_SCAN_SCHEDULER -- requirements
Module: ssd_scan_scheduler

Interface
REQ-001 Parameter SCAN_PERIOD, 262144, clk cycles per digit slot (>=2).
REQ-002 Parameter FLASH_TICKS, 64, scan ticks per flash on/off phase (>=1).
REQ-003 Parameter FLASH_TOGGLES, 6, number of phase changes per flash request (>=1).
REQ-004 clk  in  1  system clock; the block's only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 digit_data  in  32  hex value for digit i on bits [4i+3:4i], i=0..7.
REQ-007 digit_en  in  8  per-digit enable; disabled digits get no scan slot.
REQ-008 dp_mask  in  8  decimal point request per digit, active-high.
REQ-009 blank_zero  in  8  per-digit: show blank segments when that digit's value is 0.
REQ-010 flash_req  in  1  single-cycle pulse; starts or restarts a display flash.
REQ-011 an  out  8  anode drive, active-low, registered.
REQ-012 cath  out  8  {a,b,c,d,e,f,g,dp}, active-low, registered.
REQ-013 scan_tick  out  1  one-cycle pulse at each slot boundary.
REQ-014 flash_busy  out  1  high while the flash sequence runs.

Function
REQ-015 Prescaler SHALL count 0..SCAN_PERIOD-1 and wrap; scan_tick SHALL be high on the cycle after it reaches SCAN_PERIOD-1.
REQ-016 Digit pointer ptr (3 bits) SHALL, on scan_tick, advance to the next enabled index above ptr, searching circularly (7 wraps to 0).
REQ-017 If ptr is the only enabled digit, ptr SHALL hold. If no digit is enabled, ptr SHALL hold and an SHALL be 8'hFF.
REQ-018 On the scan_tick cycle, an SHALL be 8'hFF (one blanking cycle against ghosting). The new digit SHALL drive from the next cycle.
REQ-019 Otherwise an SHALL be all ones except bit ptr, which SHALL be 0, when digit_en[ptr]=1.
REQ-020 If digit_en[ptr] deasserts mid-slot, an SHALL go 8'hFF one cycle later. ptr SHALL move only at the next scan_tick.
REQ-021 cath[7:1] SHALL decode digit_data[ptr] with the team hex table (0->0000001, 1->1001111, 2->0010010, 3->0000110, 4->1001100, 5->0100100, 6->0100000, 7->0001111, 8->0000000, 9->0000100, A->0001000, B->1100000, C->0110001, D->1000010, E->0110000, F->0111000).
REQ-022 cath[0] SHALL equal ~dp_mask[ptr].
REQ-023 If blank_zero[ptr]=1 and the digit value is 0, cath[7:1] SHALL be 7'h7F; dp SHALL be unaffected.
REQ-024 an and cath SHALL reflect input changes with exactly one cycle of latency.
REQ-025 Flash FSM states SHALL be IDLE, OFF and ON.
REQ-026 flash_req in any state SHALL go to OFF and clear the phase-tick and toggle counters (retrigger).
REQ-027 In OFF or ON, after FLASH_TICKS scan_ticks the FSM SHALL switch phase and increment the toggle count.
REQ-028 When the toggle count reaches FLASH_TOGGLES, the FSM SHALL return to IDLE instead of switching phase.
REQ-029 In OFF, an SHALL be 8'hFF. The prescaler and ptr SHALL keep running in every state.
REQ-030 flash_busy SHALL be high in OFF and ON and low in IDLE, registered with the state.

Reset
REQ-031 rst SHALL dominate all inputs, including a flash_req in the same cycle.
REQ-032 Reset values: prescaler=0, ptr=0, FSM=IDLE, counters=0, an=8'hFF, cath=8'hFF, scan_tick=0, flash_busy=0.
REQ-033 rst asserted mid-slot or mid-flash SHALL produce the reset values on the next cycle.

Verification (SCAN_PERIOD=4, FLASH_TICKS=2, FLASH_TOGGLES=4)
REQ-034 digit_en=8'h83, data=0x50000021 -> an cycles FE, FD, 7F with one FF cycle per boundary; scan_tick every 4 cycles; cath shows 1, 2, 5.
REQ-035 digit_en=0 -> an stays FF. Then set digit_en=8'h10 -> ptr reaches 4 within one slot and holds; an=EF except FF on tick cycles.
REQ-036 digit 0 value 0 with blank_zero[0]=1 and dp_mask[0]=1 -> cath=8'hFE. With blank_zero[0]=0 -> cath=8'h02.
REQ-037 flash_req pulse -> flash_busy high for 4x2 scan_ticks, pattern OFF, ON, OFF, ON, then IDLE. A second pulse mid-sequence restarts the full 8-tick sequence.
REQ-038 rst together with flash_req during an active slot -> next cycle an=FF, cath=FF, flash_busy=0, ptr=0.
REQ-039 Clear digit_en[ptr] mid-slot -> an=FF one cycle later; ptr advances at the next tick to the next enabled digit.
